// File: rtl/adder_arbiter_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// State encodings are fixed so that waveform viewers and external monitors agree.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned DefWidth  = 4;
  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefCntW   = 16;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above ptr_i,
// wrapping modulo NumReq, so the last winner has the lowest priority next time.
module rr_arbiter #(
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    gnt_idx_o
);

  logic           found;
  logic [IdW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = IdW'((int'(ptr_i) + k) % NumReq);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/cl_adder.sv
// Unsigned carry-lookahead adder, no carry-in.
// The result is {carry_o, result_o} = a_i + b_i.
module cl_adder #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o
);

  logic [Width-1:0] gen;
  logic [Width-1:0] prop;
  logic [Width:0]   carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  always_comb begin
    carry = '0;
    for (int i = 0; i < Width; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign result_o = prop ^ carry[Width-1:0];
  assign carry_o  = carry[Width];

endmodule

// File: rtl/adder_arbiter.sv
// Shares one cl_adder between NumReq valid/ready requesters, round-robin.
// One op in flight: operands registered at accept, result registered after CALC.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int Width  = DefWidth,
  parameter  int NumReq = DefNumReq,
  parameter  int CntW   = DefCntW,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_a_i,
  input  logic [NumReq*Width-1:0] req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdW-1:0]          rsp_id_o,
  output logic [Width-1:0]        rsp_result_o,
  output logic                    rsp_carry_o,
  output logic                    busy_o,
  output logic [CntW-1:0]         ops_done_o
);

  state_e                       state_q;
  logic [IdW-1:0]               rr_ptr_q;
  logic [IdW-1:0]               id_q;
  logic [Width-1:0]             a_q, b_q, res_q;
  logic                         carry_q;
  logic [CntW-1:0]              cnt_q;

  logic [NumReq-1:0][Width-1:0] a_arr, b_arr;
  logic [NumReq-1:0]            gnt;
  logic [IdW-1:0]               gnt_idx;
  logic                         arb_en, accept;
  logic [Width-1:0]             sum;
  logic                         cout;

  assign a_arr = req_a_i;
  assign b_arr = req_b_i;

  // rst_ni gates the grant so req_ready_o is already low while reset is held.
  assign arb_en = rst_ni &&
                  ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i));
  assign accept = |gnt;

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  cl_adder #(.Width(Width)) u_add (
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (sum),
    .carry_o  (cout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IdW'(NumReq - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) state_q <= S_CALC;
        S_CALC: begin
          res_q   <= sum;
          carry_q <= cout;
          state_q <= S_RESP;
        end
        S_RESP: if (rsp_ready_i) begin
          cnt_q   <= cnt_q + CntW'(1);
          state_q <= accept ? S_CALC : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // accept is only ever high in IDLE or in a completing RESP
      if (accept) begin
        a_q      <= a_arr[gnt_idx];
        b_q      <= b_arr[gnt_idx];
        id_q     <= gnt_idx;
        rr_ptr_q <= gnt_idx;
      end
    end
  end

  assign req_ready_o  = gnt;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
  assign rsp_carry_o  = carry_q;
  assign ops_done_o   = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed cases plus randomized traffic,
// checked against a queue-based model of round-robin grant and a+b results.
module tb_adder_arbiter;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_result;
  logic            rsp_carry, busy;
  logic [CW-1:0]   ops_done;

  always #5 clk = ~clk;

  adder_arbiter #(.Width(W), .NumReq(N), .CntW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_carry_o(rsp_carry),
    .busy_o(busy), .ops_done_o(ops_done)
  );

  typedef struct { int id; int sum; int cyc; } exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   tests = 0, fails = 0, cyc = 0, mptr = N - 1, mcnt = 0;
  logic [N-1:0] acc_mask = '0;

  // negedge-block scratch (module scope so it is recomputed every cycle)
  bit           hs, can_acc;
  int           g;
  logic [N-1:0] exp_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: model is "one op in flight, result two edges after accept".
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mptr     = N - 1;
      mcnt     = 0;
      acc_mask = '0;
    end else begin
      hs      = rsp_valid && rsp_ready;
      can_acc = (sb.size() == 0) || (sb.size() == 1 && hs);
      g       = rr_pick(req_valid, mptr);
      exp_rdy = '0;
      if (can_acc && g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, sb.size() != 0);
      chk("rsp_valid", rsp_valid, sb.size() > 0 && cyc >= sb[0].cyc + 2);
      chk("ops_done", ops_done, mcnt);
      if (rsp_valid && sb.size() > 0) begin
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_result", rsp_result, sb[0].sum % 16);
        chk("rsp_carry", rsp_carry, sb[0].sum / 16);
      end
      if (hs && sb.size() > 0) begin
        void'(sb.pop_front());
        mcnt = (mcnt + 1) % (1 << CW);
      end
      acc_mask = req_ready & req_valid;
      if (can_acc && g >= 0) begin
        sb.push_back('{g, int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]), cyc});
        mptr = g;
        grant_log.push_back(g);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL timeout %s (cycle %0d)", name, cyc);
  endtask

  task automatic set_op(input int r, input int a, input int b);
    req_a[r*W +: W] = W'(a);
    req_b[r*W +: W] = W'(b);
  endtask

  task automatic hold_until_accepted(input int budget);
    int n = 0;
    while (req_valid != '0 && n < budget) begin
      step();
      req_valid &= ~acc_mask;
      n++;
    end
    if (req_valid != '0) timeout("accept");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) timeout("drain");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rvalid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ops"}, ops_done, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_res"}, rsp_result, 0);
    chk({tag, "_carry"}, rsp_carry, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n     = 1'b1;
    req_valid = '1;
    req_a     = N*W'($urandom);
    req_b     = N*W'($urandom);
    rsp_ready = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    req_valid = '0;
    rst_n     = 1'b1;

    // single op: 4 + F
    step();
    set_op(0, 4, 15);
    req_valid = 4'b0001;
    hold_until_accepted(10);
    wait_idle(20);
    chk("single_id", rsp_id, 0);
    chk("single_res", rsp_result, 3);
    chk("single_carry", rsp_carry, 1);
    chk("single_ops", ops_done, 1);

    // wrap: r3 then r0
    set_op(3, 15, 1);
    req_valid = 4'b1000;
    hold_until_accepted(10);
    wait_idle(20);
    chk("wrap_id3", rsp_id, 3);
    chk("wrap_res", rsp_result, 0);
    chk("wrap_carry", rsp_carry, 1);
    set_op(0, $urandom, $urandom);
    req_valid = 4'b0001;
    hold_until_accepted(10);
    wait_idle(20);
    chk("wrap_id0", rsp_id, 0);

    // back-pressure: r1 served, r2 waits behind a stalled response
    rsp_ready = 1'b0;
    set_op(1, $urandom, $urandom);
    set_op(2, $urandom, $urandom);
    req_valid = 4'b0110;
    n = 0;
    do begin step(); n++; end while (!acc_mask[1] && n < 10);
    req_valid[1] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    if (!rsp_valid) timeout("bp_rsp");
    repeat (5) step();
    rsp_ready = 1'b1;
    #1;
    chk("bp_same_cycle_grant", req_ready, 4'b0100);
    hold_until_accepted(10);
    wait_idle(20);

    // reset while in CALC, then contention from a clean pointer
    set_op(1, $urandom, $urandom);
    req_valid = 4'b0010;
    hold_until_accepted(10);
    req_valid = '1;
    rst_n     = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) step();
    grant_log.delete();
    rst_n = 1'b1;
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin step(); n++; end
    req_valid = '0;
    wait_idle(20);
    chk("cont_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("cont_order", grant_log[i], exp_order[i]);
    chk("cnt_wrap", ops_done, 1);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      step();
      req_valid &= ~acc_mask;
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          set_op(r, $urandom, $urandom);
          req_valid[r] = 1'b1;
        end else if (req_valid[r] && $urandom_range(0, 9) == 0) begin
          req_valid[r] = 1'b0;
        end else if (req_valid[r] && $urandom_range(0, 7) == 0) begin
          set_op(r, $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
